// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV64 control sequencer with memory watchdog and retire counter
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic [3:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_ADDR    = 4'd5,
    S_MEM_RD  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t     cur;
  logic [7:0] wait_cnt;
  logic       trap_r;
  logic [1:0] cause_r;

  // Sequencer: next state, watchdog, sticky trap and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      retired  <= '0;
      trap_r   <= 1'b0;
      cause_r  <= 2'b00;
    end else begin
      // wait_cnt only survives a cycle spent stalling in a memory state
      wait_cnt <= 8'd0;
      case (cur)
        S_FETCH: begin
          if (mem_ready) begin
            cur <= S_DECODE;
          end else if (wait_cnt == WAIT_MAX) begin
            cur     <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (opcode == OP_R) begin
            cur <= S_EXEC_R;
          end else if (opcode == OP_I) begin
            cur <= S_EXEC_I;
          end else if (opcode == OP_LD || opcode == OP_SD) begin
            cur <= S_ADDR;
          end else if (opcode == OP_BEQ) begin
            cur <= S_BRANCH;
          end else begin
            cur     <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b01;
          end
        end
        S_EXEC_R: cur <= S_ALU_WB;
        S_EXEC_I: cur <= S_ALU_WB;
        S_ALU_WB: begin
          cur     <= S_FETCH;
          retired <= retired + ONE;
        end
        S_ADDR: cur <= (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready) begin
            cur <= S_LOAD_WB;
          end else if (wait_cnt == WAIT_MAX) begin
            cur     <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_LOAD_WB: begin
          cur     <= S_FETCH;
          retired <= retired + ONE;
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            cur     <= S_FETCH;
            retired <= retired + ONE;
          end else if (wait_cnt == WAIT_MAX) begin
            cur     <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_BRANCH: begin
          cur     <= S_FETCH;
          retired <= retired + ONE;
        end
        S_TRAP: cur <= S_TRAP;
        default: begin
          cur     <= S_TRAP;
          trap_r  <= 1'b1;
          cause_r <= 2'b01;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  assign state      = cur;
  assign trap       = trap_r;
  assign trap_cause = cause_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic          alu_src_a, pc_src, trap;
  logic [1:0]    alu_src_b, alu_op, trap_cause;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;
  int ret_exp = 0;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clock = ~clock;

  logic [13:0] ctrl;
  assign ctrl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_src, trap};

  // Control table: what the datapath must see in each architectural step
  function automatic logic [13:0] exp_ctrl(input int st, input logic mr, input logic z);
    logic pcw, irw, io, mrd, mwr, rw, m2r, sa, psrc, tr;
    logic [1:0] sb, op;
    {pcw, irw, io, mrd, mwr, rw, m2r, sa, psrc, tr} = '0;
    sb = 2'b00;
    op = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; op = 2'b10; end
      3:  begin sa = 1; sb = 2'b10; op = 2'b11; end
      4:  rw = 1;
      5:  begin sa = 1; sb = 2'b10; end
      6:  begin mrd = 1; io = 1; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin mwr = 1; io = 1; end
      9:  begin sa = 1; op = 2'b01; psrc = 1; pcw = z; end
      15: tr = 1;
      default: ;
    endcase
    return {pcw, irw, io, mrd, mwr, rw, m2r, sa, sb, op, psrc, tr};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ret_exp = 0;
  endtask

  // Runs one instruction: expected step list built from its class and latencies
  task automatic run_instr(input logic [6:0] op, input int flat, input int mlat);
    int   sts[$];
    logic mrs[$];
    for (int i = 0; i < flat; i++) begin sts.push_back(0); mrs.push_back(1'b0); end
    sts.push_back(0); mrs.push_back(1'b1);
    sts.push_back(1); mrs.push_back(1'($urandom));
    case (op)
      7'b0110011: begin sts.push_back(2); sts.push_back(4); mrs.push_back(1'($urandom)); mrs.push_back(1'($urandom)); end
      7'b0010011: begin sts.push_back(3); sts.push_back(4); mrs.push_back(1'($urandom)); mrs.push_back(1'($urandom)); end
      7'b0000011: begin
        sts.push_back(5); mrs.push_back(1'($urandom));
        for (int i = 0; i < mlat; i++) begin sts.push_back(6); mrs.push_back(1'b0); end
        sts.push_back(6); mrs.push_back(1'b1);
        sts.push_back(7); mrs.push_back(1'($urandom));
      end
      7'b0100011: begin
        sts.push_back(5); mrs.push_back(1'($urandom));
        for (int i = 0; i < mlat; i++) begin sts.push_back(8); mrs.push_back(1'b0); end
        sts.push_back(8); mrs.push_back(1'b1);
      end
      default: begin sts.push_back(9); mrs.push_back(1'($urandom)); end
    endcase
    opcode = op;
    foreach (sts[i]) begin
      mem_ready = mrs[i];
      if (op != 7'b1100011) zero = 1'($urandom);
      #1;
      checks++;
      if (state !== 4'(sts[i])) begin
        errors++;
        $display("FAIL seq_state op=%b step=%0d got=%0d exp=%0d", op, i, state, sts[i]);
      end
      checks++;
      if (ctrl !== exp_ctrl(sts[i], mrs[i], zero)) begin
        errors++;
        $display("FAIL seq_ctrl op=%b step=%0d st=%0d got=%b exp=%b", op, i, sts[i], ctrl, exp_ctrl(sts[i], mrs[i], zero));
      end
      @(posedge clock);
      #1;
    end
    ret_exp = (ret_exp + 1) % (1 << CW);
    checks++;
    if (retired !== CW'(ret_exp)) begin
      errors++;
      $display("FAIL retired op=%b got=%0d exp=%0d", op, retired, ret_exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, trap, trap_cause, retired} !== {4'd0, 1'b0, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL reset_state got st=%0d trap=%b cause=%b ret=%0d exp 0/0/00/0", state, trap, trap_cause, retired);
    end
    #1;
    checks++;
    if (ctrl !== exp_ctrl(0, 1'b0, zero)) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b", ctrl, exp_ctrl(0, 1'b0, zero));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_rtype();
    do_reset();
    run_instr(7'b0110011, 0, 0);
  endtask

  task automatic test_load();
    do_reset();
    run_instr(7'b0000011, 0, 3);
  endtask

  task automatic test_branch();
    do_reset();
    zero = 1'b1;
    run_instr(7'b1100011, 0, 0);
    zero = 1'b0;
    run_instr(7'b1100011, 1, 0);
    checks++;
    if (retired !== CW'(2)) begin
      errors++;
      $display("FAIL branch_retired got=%0d exp=2", retired);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      #1;
      checks++;
      if ({state, ctrl, trap_cause} !== {4'd15, exp_ctrl(15, mem_ready, zero), 2'b01}) begin
        errors++;
        $display("FAIL illegal_hold cyc=%0d got st=%0d ctrl=%b cause=%b exp st=15 ctrl=%b cause=01", i, state, ctrl, trap_cause, exp_ctrl(15, 1'b0, 1'b0));
      end
      @(posedge clock); #1;
    end
    do_reset();
    checks++;
    if ({state, trap, trap_cause} !== {4'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL illegal_reset got st=%0d trap=%b cause=%b exp 0/0/00", state, trap, trap_cause);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || mem_read !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait cyc=%0d got st=%0d mem_read=%b exp 0/1", i, state, mem_read);
      end
      @(posedge clock); #1;
    end
    checks++;
    if ({state, trap, trap_cause} !== {4'd15, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL timeout_trap got st=%0d trap=%b cause=%b exp 15/1/10", state, trap, trap_cause);
    end
    do_reset();
    run_instr(7'b0110011, TO, 0);
    run_instr(7'b0000011, 0, TO);
    run_instr(7'b0100011, TO, TO);
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_ok got trap=%b exp 0", trap);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(7'b0010011, 0, 0);
    checks++;
    if (retired !== CW'(1)) begin
      errors++;
      $display("FAIL wrap got=%0d exp=1", retired);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [5];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      zero = 1'($urandom);
      run_instr(ops[$urandom_range(0, 4)], int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));
    end
  endtask

  task automatic test_reset_midwr();
    do_reset();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clock); #1; end
    checks++;
    if (state !== 4'd8 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL midwr_pre got st=%0d mem_write=%b exp 8/1", state, mem_write);
    end
    do_reset();
    #1;
    checks++;
    if ({state, mem_write, retired} !== {4'd0, 1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL midwr_reset got st=%0d mem_write=%b ret=%0d exp 0/0/0", state, mem_write, retired);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_illegal();
    test_timeout();
    test_wrap();
    test_random();
    test_reset_midwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
